// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC arctangent table, gain constant, turn constants and vectoring FSM states
package cordic_pkg;
  localparam logic [19:0] CORDIC_ATAN_LUT [0:17] = '{
    20'h20000, 20'h12E40, 20'h09FB4, 20'h05111, 20'h028B1, 20'h0145D,
    20'h00A2F, 20'h00518, 20'h0028C, 20'h00146, 20'h000A3, 20'h00051,
    20'h00029, 20'h00014, 20'h0000A, 20'h00005, 20'h00003, 20'h00001
  };
  localparam logic [15:0] CORDIC_INV_GAIN = 16'h9B75;
  localparam logic [19:0] CORDIC_TURN_180 = 20'h80000;
  localparam logic [19:0] CORDIC_TURN_90  = 20'h40000;
  typedef enum logic [1:0] {IDLE, ROTATE, COMP, DONE} cordic_state_t;
endpackage

// File: rtl/cordic_vec_step.sv
// cordic_vec_step: one vectoring micro-rotation, direction chosen to drive y toward zero
module cordic_vec_step
  import cordic_pkg::*;
#(
  parameter int XW = 22,
  parameter int AW = 20
) (
  input  logic signed [XW-1:0] i_x,
  input  logic signed [XW-1:0] i_y,
  input  logic        [AW-1:0] i_z,
  input  logic        [4:0]    i_i,
  output logic signed [XW-1:0] o_x,
  output logic signed [XW-1:0] o_y,
  output logic        [AW-1:0] o_z
);
  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;
  logic        [AW-1:0] w_ang;
  logic                 w_neg;
  assign w_xs  = i_x >>> i_i;
  assign w_ys  = i_y >>> i_i;
  assign w_ang = AW'(CORDIC_ATAN_LUT[i_i]);
  assign w_neg = i_y[XW-1];
  assign o_x   = w_neg ? i_x - w_ys : i_x + w_ys;
  assign o_y   = w_neg ? i_y + w_xs : i_y - w_xs;
  assign o_z   = w_neg ? i_z - w_ang : i_z + w_ang;
endmodule

// File: rtl/cordic_vec_iter.sv
// cordic_vec_iter: folded CORDIC vectoring engine, (x, y) -> (phase in turns, magnitude)
module cordic_vec_iter
  import cordic_pkg::*;
#(
  parameter int DW        = 20,
  parameter int AW        = 20,
  parameter int ITER      = 16,
  parameter int GAIN_COMP = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_x,
  input  logic signed [DW-1:0] s_y,
  input  logic        [AW+1:0] s_tag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic        [AW-1:0] m_phase,
  output logic        [DW:0]   m_mag,
  output logic        [AW+1:0] m_tag
);
  localparam int XW = DW + 2;
  if (AW != 20 || ITER < 1 || ITER > 18) begin : g_bad_cfg
    $error("cordic_vec_iter: AW must be 20 and ITER must be 1..18");
  end
  cordic_state_t        r_state;
  cordic_state_t        w_next;
  logic [4:0]           r_cnt;
  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic signed [XW-1:0] w_x;
  logic signed [XW-1:0] w_y;
  logic [AW-1:0]        r_z;
  logic [AW-1:0]        w_z;
  logic [AW-1:0]        r_phase;
  logic [DW:0]          r_mag;
  logic [DW:0]          w_mag;
  logic [AW+1:0]        r_tag;
  logic [AW+1:0]        r_mtag;
  logic                 r_zero;
  logic                 w_last;
  logic                 w_neg_in;
  logic signed [XW+16:0] w_prod;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = s_valid ? ROTATE : IDLE;
      ROTATE:  w_next = w_last ? COMP : ROTATE;
      COMP:    w_next = DONE;
      DONE:    w_next = m_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    s_ready = r_state == IDLE;
    m_valid = r_state == DONE;
  end
  assign w_last   = r_cnt == 5'(ITER - 1);
  assign w_neg_in = s_x[DW-1];
  cordic_vec_step #(.XW(XW), .AW(AW)) u_step (
    .i_x(r_x), .i_y(r_y), .i_z(r_z), .i_i(r_cnt),
    .o_x(w_x), .o_y(w_y), .o_z(w_z)
  );
  // x is non-negative after the half-plane fold, so an unsigned gain factor is safe
  assign w_prod = (XW+17)'(r_x) * (XW+17)'($signed({1'b0, CORDIC_INV_GAIN}));
  assign w_mag  = GAIN_COMP != 0 ? (DW+1)'(w_prod >>> 16) : (DW+1)'(r_x);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_tag   <= '0;
      r_zero  <= 1'b0;
      r_phase <= '0;
      r_mag   <= '0;
      r_mtag  <= '0;
    end else if (r_state == IDLE && s_valid) begin
      r_x    <= w_neg_in ? -XW'(s_x) : XW'(s_x);
      r_y    <= w_neg_in ? -XW'(s_y) : XW'(s_y);
      r_z    <= w_neg_in ? AW'(CORDIC_TURN_180) : '0;
      r_tag  <= s_tag;
      r_zero <= s_x == '0 && s_y == '0;
      r_cnt  <= '0;
    end else if (r_state == ROTATE) begin
      r_x   <= w_x;
      r_y   <= w_y;
      r_z   <= w_z;
      r_cnt <= w_last ? r_cnt : r_cnt + 5'd1;
    end else if (r_state == COMP) begin
      r_phase <= r_zero ? '0 : r_z;
      r_mag   <= r_zero ? '0 : w_mag;
      r_mtag  <= r_tag;
    end
  assign m_phase = r_phase;
  assign m_mag   = r_mag;
  assign m_tag   = r_mtag;
endmodule

// File: tb/tb_cordic_vec_iter.sv
// tb_cordic_vec_iter: scoreboard bench comparing the engine against floating-point atan2/hypot
module tb_cordic_vec_iter;
  localparam int DW   = 20;
  localparam int AW   = 20;
  localparam int ITER = 16;
  localparam longint TURN = 1048576;
  logic                 clk     = 1'b0;
  logic                 rst_n   = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 m_ready = 1'b0;
  logic signed [DW-1:0] s_x     = '0;
  logic signed [DW-1:0] s_y     = '0;
  logic [AW+1:0]        s_tag   = '0;
  logic                 s_ready, m_valid, raw_s_ready, raw_m_valid;
  logic [AW-1:0]        m_phase, raw_phase;
  logic [DW:0]          m_mag, raw_mag;
  logic [AW+1:0]        m_tag, raw_tag;
  typedef struct {
    logic [AW+1:0] tag;
    longint ph, ph_tol, mag, mag_tol, raw, raw_tol, acc;
  } exp_t;
  exp_t   sb[$];
  exp_t   e_cur;
  int     n_chk  = 0;
  int     n_pass = 0;
  longint cyc    = 0;
  logic   mv_prev = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cordic_vec_iter #(.DW(DW), .AW(AW), .ITER(ITER), .GAIN_COMP(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_tag(s_tag), .m_valid(m_valid), .m_ready(m_ready),
    .m_phase(m_phase), .m_mag(m_mag), .m_tag(m_tag)
  );
  cordic_vec_iter #(.DW(DW), .AW(AW), .ITER(ITER), .GAIN_COMP(0)) u_raw (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(raw_s_ready),
    .s_x(s_x), .s_y(s_y), .s_tag(s_tag), .m_valid(raw_m_valid), .m_ready(m_ready),
    .m_phase(raw_phase), .m_mag(raw_mag), .m_tag(raw_tag)
  );
  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol, input longint modv);
    longint d;
    d = got - exp;
    n_chk++;
    if (modv != 0) begin
      d = d % modv;
      if (d < 0) d += modv;
      if (d >= modv / 2) d -= modv;
    end
    if (d > tol || d < -tol)
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    else
      n_pass++;
  endtask
  function automatic exp_t model(input int x, input int y, input logic [AW+1:0] tag);
    exp_t e;
    real  rx, ry, r, ph, k;
    rx = x;
    ry = y;
    k  = 1.6467602581;
    r  = $sqrt(rx * rx + ry * ry);
    e.tag = tag;
    e.acc = 0;
    if (x == 0 && y == 0) begin
      e.ph = 0; e.ph_tol = 0; e.mag = 0; e.mag_tol = 0; e.raw = 0; e.raw_tol = 0;
    end else begin
      ph = $atan2(ry, rx) / (2.0 * 3.14159265358979) * 1048576.0;
      if (ph < 0.0) ph += 1048576.0;
      e.ph      = longint'(ph) % TURN;
      e.ph_tol  = 12 + longint'(600000.0 / r);
      e.mag     = longint'(r);
      e.mag_tol = 8 + longint'(r / 10000.0);
      e.raw     = longint'(r * k);
      e.raw_tol = 16 + longint'(r * k / 10000.0);
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (m_valid && !mv_prev) begin
      if (sb.size() == 0) check("spurious_valid", 1, 0, 0, 0);
      else check("latency", cyc - sb[0].acc, ITER + 1, 0, 0);
    end
    if (m_valid && m_ready && sb.size() != 0) begin
      e_cur = sb.pop_front();
      check("tag", longint'(m_tag), longint'(e_cur.tag), 0, 0);
      check("phase", longint'(m_phase), e_cur.ph, e_cur.ph_tol, TURN);
      check("mag", longint'(m_mag), e_cur.mag, e_cur.mag_tol, 0);
      check("raw_mag", longint'(raw_mag), e_cur.raw, e_cur.raw_tol, 0);
      check("raw_sync", longint'({raw_m_valid, raw_tag, raw_phase}),
            longint'({m_valid, m_tag, m_phase}), 0, 0);
    end
    mv_prev <= m_valid;
  end
  task automatic send(input int x, input int y, input logic [AW+1:0] tag);
    exp_t e;
    int   n;
    n = 0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_x     = DW'(x);
    s_y     = DW'(y);
    s_tag   = tag;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("accept_timeout", 0, 1, 0, 0);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e     = model(x, y, tag);
    e.acc = cyc;
    sb.push_back(e);
    s_valid = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", longint'(sb.size()), 0, 0, 0);
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int   n, bad, seen;
    logic [AW-1:0] ph0;
    logic [DW:0]   mag0;
    logic [AW+1:0] tag0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", longint'(s_ready), 1, 0, 0);
    check("rst_m_valid", longint'(m_valid), 0, 0, 0);
    check("rst_phase", longint'(m_phase), 0, 0, 0);
    check("rst_mag", longint'(m_mag), 0, 0, 0);
    check("rst_tag", longint'(m_tag), 0, 0, 0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    send(1000, 0, 22'h10);
    send(707, 707, 22'h11);
    send(0, 1000, 22'h12);
    send(-1000, 0, 22'h13);
    send(0, -1000, 22'h14);
    send(-1000, -1, 22'h15);
    send(-524288, -524288, 22'h16);
    send(0, 0, 22'h3ABCD);
    send(524287, -524288, 22'h17);
    for (int i = 0; i < 16; i++)
      send(int'($urandom_range(0, 1048575)) - 524288,
           int'($urandom_range(0, 1048575)) - 524288, 22'(32 + i));
    drain();
    m_ready = 1'b0;
    send(300, -400, 22'd1);
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", longint'(m_valid), 1, 0, 0);
    ph0  = m_phase;
    mag0 = m_mag;
    tag0 = m_tag;
    bad  = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      s_valid = i[0];
      s_x     = DW'(i * 1000);
      s_y     = DW'(-i * 700);
      s_tag   = 22'(200 + i);
      @(negedge clk);
      if (s_ready || raw_s_ready || !m_valid || m_phase != ph0 || m_mag != mag0 || m_tag != tag0)
        bad++;
    end
    check("bp_hold", longint'(bad), 0, 0, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_s_ready_before", longint'(s_ready), 0, 0, 0);
    @(negedge clk);
    check("bp_s_ready_after", longint'(s_ready), 1, 0, 0);
    check("bp_valid_drop", longint'(m_valid), 0, 0, 0);
    send(-250, 600, 22'd2);
    send(1000, -1000, 22'd3);
    drain();
    send(500, 200, 22'd7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_s_ready", longint'(s_ready), 1, 0, 0);
    check("rst_mid_m_valid", longint'(m_valid), 0, 0, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (ITER + 5) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    check("rst_no_valid", longint'(seen), 0, 0, 0);
    send(-700, 300, 22'd8);
    drain();
    check("sb_empty", longint'(sb.size()), 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
